mio_bus_responder: RTL

Memory/IO-side responder for the pipelined CPU's data-memory bus: it accepts the CPU's load/store requests, routes them to on-chip synchronous data RAM or to a small memory-mapped IO register set, and returns read data with a one-cycle `MIO_ready`-style completion pulse. It sits between the CPU's MEM-stage outputs (address, store data, write enable, request) and the data RAM/peripherals, as the other end of that interface.

---
 rtl/mio_bus_pkg.sv | 52 +++++
 rtl/mio_io_regs.sv | 76 +++++++
 rtl/mio_bus_responder.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/mio_bus_pkg.sv
`default_nettype none
// ============================================================================
// mio_bus_pkg
// Shared types and constants for the memory/IO bus responder: FSM state
// encoding, decoded target region, IO register byte offsets and the
// address-region decode helper.
// Rev 1.0 - initial release
// ============================================================================
package mio_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RAM_ISSUE = 3'd1,
    ST_RAM_DATA  = 3'd2,
    ST_IO_WAIT   = 3'd3,
    ST_ERR       = 3'd4,
    ST_RESP      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    REGION_RAM = 2'd0,
    REGION_IO  = 2'd1,
    REGION_ERR = 2'd2
  } region_t;

  // IO register byte offsets within the 16-byte IO window
  localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
  localparam logic [3:0] OFF_GPIO_IN  = 4'h4;
  localparam logic [3:0] OFF_COUNTER  = 4'h8;
  localparam logic [3:0] OFF_STATUS   = 4'hC;

  // Top nibble that selects the RAM region
  localparam logic [3:0] RAM_REGION_TAG = 4'h0;

  // Misalignment is checked first so a misaligned IO address is an error,
  // not an IO access.
  function automatic region_t decode_region(input logic [31:0] addr,
                                            input logic [31:0] io_base,
                                            input int unsigned ram_bits);
    logic [25:0] word;
    word = addr[27:2];
    if (addr[1:0] != 2'b00)
      return REGION_ERR;
    if (addr[31:28] == RAM_REGION_TAG && (word >> ram_bits) == 26'd0)
      return REGION_RAM;
    if (addr[31:4] == io_base[31:4])
      return REGION_IO;
    return REGION_ERR;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mio_io_regs.sv
`default_nettype none
// ============================================================================
// mio_io_regs
// Memory-mapped IO register set: GPIO output register, free-running 32-bit
// counter, sticky bus-error flag and the combinational read mux.
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   strobe        - one-cycle access strobe from the responder FSM
//   we            - access is a write
//   sel           - register word select (byte offset [3:2])
//   wdata         - write data
//   err_set       - set bus_err this edge (beats a status clear)
//   gpio_in       - GPIO input pins
//   gpio_out      - GPIO output register
//   bus_err       - sticky error flag
//   rdata         - read-mux output for the selected register
// Rev 1.0 - initial release
// ============================================================================
module mio_io_regs
  import mio_bus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        strobe,
  input  logic        we,
  input  logic [1:0]  sel,
  input  logic [31:0] wdata,
  input  logic        err_set,
  input  logic [31:0] gpio_in,
  output logic [31:0] gpio_out,
  output logic        bus_err,
  output logic [31:0] rdata
);

  logic [31:0] counter;
  logic [3:0]  offset;
  logic        wr;

  assign offset = {sel, 2'b00};
  assign wr     = strobe && we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gpio_out <= 32'h0;
      counter  <= 32'h0;
      bus_err  <= 1'b0;
    end else begin
      if (wr && offset == OFF_GPIO_OUT)
        gpio_out <= wdata;

      // A write replaces this edge's increment
      if (wr && offset == OFF_COUNTER)
        counter <= wdata;
      else
        counter <= counter + 32'd1;

      if (err_set)
        bus_err <= 1'b1;
      else if (wr && offset == OFF_STATUS && wdata[0])
        bus_err <= 1'b0;
    end
  end

  always_comb begin
    rdata = 32'h0;
    case (offset)
      OFF_GPIO_OUT: rdata = gpio_out;
      OFF_GPIO_IN:  rdata = gpio_in;
      OFF_COUNTER:  rdata = counter;
      OFF_STATUS:   rdata = {31'b0, bus_err};
      default:      rdata = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mio_bus_responder.sv
`default_nettype none
// ============================================================================
// mio_bus_responder
// Data-memory bus responder: accepts CPU load/store requests, routes them to
// a synchronous data RAM or the IO register block, and returns read data with
// a one-cycle completion pulse. All outputs are registered.
// Ports:
//   clk, rst                      - clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata         - CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready          - response data and completion pulse
//   ram_en/we/addr/wdata          - synchronous RAM port
//   ram_rdata                     - RAM read data (cycle after ram_en edge)
//   gpio_out, gpio_in             - GPIO register / input pins
//   bus_err                       - sticky error flag
// Rev 1.0 - initial release
// ============================================================================
module mio_bus_responder
  import mio_bus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS = 10,
  parameter int unsigned IO_WAIT       = 2,
  parameter logic [31:0] IO_BASE       = 32'hF000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [31:0]              cpu_addr,
  input  logic [31:0]              cpu_wdata,
  output logic [31:0]              cpu_rdata,
  output logic                     cpu_ready,
  output logic                     ram_en,
  output logic                     ram_we,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [31:0]              ram_wdata,
  input  logic [31:0]              ram_rdata,
  output logic [31:0]              gpio_out,
  input  logic [31:0]              gpio_in,
  output logic                     bus_err
);

  localparam logic [3:0] IO_WAIT_INIT = 4'(IO_WAIT);

  state_t      state, state_next;
  region_t     region;
  logic [3:0]  wait_cnt, wait_next;
  logic [1:0]  sel_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_next;
  logic [31:0] io_rdata;
  logic        io_strobe;
  logic        err_set;
  logic        accept;

  assign region = decode_region(cpu_addr, IO_BASE, RAM_ADDR_BITS);
  assign accept = (state == ST_IDLE) && cpu_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_next;
    end
  end

  always_comb begin
    state_next = state;
    wait_next  = wait_cnt;
    rdata_next = cpu_rdata;
    io_strobe  = 1'b0;
    err_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cpu_req) begin
          case (region)
            REGION_RAM: state_next = ST_RAM_ISSUE;
            REGION_IO: begin
              state_next = ST_IO_WAIT;
              wait_next  = IO_WAIT_INIT;
            end
            default:    state_next = ST_ERR;
          endcase
        end
      end
      ST_RAM_ISSUE: state_next = ST_RAM_DATA;
      ST_RAM_DATA: begin
        rdata_next = we_q ? 32'h0 : ram_rdata;
        state_next = ST_RESP;
      end
      ST_IO_WAIT: begin
        if (wait_cnt != 4'd0) begin
          wait_next = wait_cnt - 4'd1;
        end else begin
          io_strobe  = 1'b1;
          rdata_next = we_q ? 32'h0 : io_rdata;
          state_next = ST_RESP;
        end
      end
      ST_ERR: begin
        err_set    = 1'b1;
        rdata_next = 32'h0;
        state_next = ST_RESP;
      end
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Registered outputs are derived from the next state so each one is
  // asserted exactly in the cycle its state is occupied.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cpu_ready <= 1'b0;
      cpu_rdata <= 32'h0;
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= 32'h0;
      sel_q     <= 2'd0;
      we_q      <= 1'b0;
      wdata_q   <= 32'h0;
    end else begin
      cpu_ready <= (state_next == ST_RESP);
      cpu_rdata <= rdata_next;
      ram_en    <= (state_next == ST_RAM_ISSUE);
      ram_we    <= (state_next == ST_RAM_ISSUE) && we_q_next();
      if (accept) begin
        sel_q   <= cpu_addr[3:2];
        we_q    <= cpu_we;
        wdata_q <= cpu_wdata;
        if (region == REGION_RAM) begin
          ram_addr  <= cpu_addr[RAM_ADDR_BITS+1:2];
          ram_wdata <= cpu_wdata;
        end
      end
    end
  end

  // The RAM write enable is issued on the accept edge, before we_q holds it
  function automatic logic we_q_next();
    return accept ? cpu_we : we_q;
  endfunction

  mio_io_regs u_io_regs (
    .clk      (clk),
    .rst      (rst),
    .strobe   (io_strobe),
    .we       (we_q),
    .sel      (sel_q),
    .wdata    (wdata_q),
    .err_set  (err_set),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .bus_err  (bus_err),
    .rdata    (io_rdata)
  );

endmodule
`default_nettype wire
